// File: rtl/tug_of_war_ctrl_if.sv
// tug_of_war_ctrl_if: player keys in, playfield/score/win status out.
// slave  = controller side (drives lights, wins, scores, match_over)
// master = player/host side (drives key_l, key_r)
interface tug_of_war_ctrl_if #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3
);
  logic                  key_l;
  logic                  key_r;
  logic [NUM_LIGHTS-1:0] lights;
  logic                  win_l;
  logic                  win_r;
  logic [SCORE_W-1:0]    score_l;
  logic [SCORE_W-1:0]    score_r;
  logic                  match_over;
  modport slave (
    input  key_l, key_r,
    output lights, win_l, win_r, score_l, score_r, match_over
  );
  modport master (
    output key_l, key_r,
    input  lights, win_l, win_r, score_l, score_r, match_over
  );
endinterface

// File: rtl/tug_of_war_ctrl.sv
// tug_of_war_ctrl: tug-of-war playfield controller (light position, round wins, scores, match end).
// Ports: clk, reset (async active-low), bus (tug_of_war_ctrl_if.slave):
//   key_l/key_r in (async levels), lights out (bit NUM_LIGHTS-1 = leftmost),
//   win_l/win_r, score_l/score_r, match_over out (registered).
module tug_of_war_ctrl #(
  parameter int NUM_LIGHTS  = 9,
  parameter int SCORE_W     = 3,
  parameter int HOLD_CYCLES = 4
) (
  input logic               clk,
  input logic               reset,
  tug_of_war_ctrl_if.slave  bus
);
  localparam int PW = $clog2(NUM_LIGHTS);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PW-1:0]         P_MAX = PW'(NUM_LIGHTS - 1);
  localparam logic [PW-1:0]         P_MID = PW'(NUM_LIGHTS / 2);
  localparam logic [CW-1:0]         C_END = CW'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0]    S_MAX = '1;
  localparam logic [NUM_LIGHTS-1:0] ONE   = 1;
  typedef enum logic [1:0] {PLAY, HOLD, DONE} state_t;
  state_t             state_q, state_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               win_l_q, win_l_d, win_r_q, win_r_d, match_q, match_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [1:0]         sync_l_q, sync_r_q;
  logic               prev_l_q, prev_r_q;
  logic               press_l, press_r;
  logic [SCORE_W-1:0] score_l_inc, score_r_inc;
  // sync_x_q[1] is the synchronised key; prev flop turns a rising edge into a one-cycle press
  assign press_l     = sync_l_q[1] & ~prev_l_q;
  assign press_r     = sync_r_q[1] & ~prev_r_q;
  assign score_l_inc = score_l_q + 1'b1;
  assign score_r_inc = score_r_q + 1'b1;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= PLAY;
      pos_q     <= P_MID;
      cnt_q     <= '0;
      win_l_q   <= 1'b0;
      win_r_q   <= 1'b0;
      match_q   <= 1'b0;
      score_l_q <= '0;
      score_r_q <= '0;
      sync_l_q  <= '0;
      sync_r_q  <= '0;
      prev_l_q  <= 1'b0;
      prev_r_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      cnt_q     <= cnt_d;
      win_l_q   <= win_l_d;
      win_r_q   <= win_r_d;
      match_q   <= match_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      sync_l_q  <= {sync_l_q[0], bus.key_l};
      sync_r_q  <= {sync_r_q[0], bus.key_r};
      prev_l_q  <= sync_l_q[1];
      prev_r_q  <= sync_r_q[1];
    end
  end
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    cnt_d     = cnt_q;
    win_l_d   = win_l_q;
    win_r_d   = win_r_q;
    match_d   = match_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    case (state_q)
      PLAY: begin
        // simultaneous presses cancel: neither branch fires
        if (press_l && !press_r) begin
          if (pos_q == P_MAX) begin
            score_l_d = score_l_inc;
            win_l_d   = 1'b1;
            cnt_d     = '0;
            match_d   = score_l_inc == S_MAX;
            state_d   = (score_l_inc == S_MAX) ? DONE : HOLD;
          end else pos_d = pos_q + 1'b1;
        end else if (press_r && !press_l) begin
          if (pos_q == '0) begin
            score_r_d = score_r_inc;
            win_r_d   = 1'b1;
            cnt_d     = '0;
            match_d   = score_r_inc == S_MAX;
            state_d   = (score_r_inc == S_MAX) ? DONE : HOLD;
          end else pos_d = pos_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == C_END) begin
          win_l_d = 1'b0;
          win_r_d = 1'b0;
          pos_d   = P_MID;
          cnt_d   = '0;
          state_d = PLAY;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end
  assign bus.lights     = (state_q == PLAY) ? (ONE << pos_q) : '0;
  assign bus.win_l      = win_l_q;
  assign bus.win_r      = win_r_q;
  assign bus.score_l    = score_l_q;
  assign bus.score_r    = score_r_q;
  assign bus.match_over = match_q;
endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// tb_tug_of_war_ctrl: directed bench for tug_of_war_ctrl; inputs driven and outputs sampled on falling edges.
module tb_tug_of_war_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  tug_of_war_ctrl_if #(.NUM_LIGHTS(9), .SCORE_W(3)) bus ();
  tug_of_war_ctrl #(.NUM_LIGHTS(9), .SCORE_W(3), .HOLD_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [8:0] lt, input logic wl, input logic wr,
                         input logic [2:0] sl, input logic [2:0] sr, input logic mo);
    chk({tag, ".lights"}, 32'(bus.lights), 32'(lt));
    chk({tag, ".win_l"}, 32'(bus.win_l), 32'(wl));
    chk({tag, ".win_r"}, 32'(bus.win_r), 32'(wr));
    chk({tag, ".score_l"}, 32'(bus.score_l), 32'(sl));
    chk({tag, ".score_r"}, 32'(bus.score_r), 32'(sr));
    chk({tag, ".match"}, 32'(bus.match_over), 32'(mo));
  endtask
  // one-cycle key pulse; returns on the falling edge right after the move takes effect
  task automatic press(input logic l, input logic r);
    bus.key_l = l;
    bus.key_r = r;
    tick(1);
    bus.key_l = 1'b0;
    bus.key_r = 1'b0;
    tick(2);
  endtask
  initial begin
    bus.key_l = 1'b0;
    bus.key_r = 1'b0;
    tick(2);
    chk_all("reset", 9'b000010000, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick(1);
    bus.key_l = 1'b1;
    tick(2);
    chk("hold5.before", 32'(bus.lights), 32'h010);
    tick(1);
    chk("hold5.moved", 32'(bus.lights), 32'h020);
    tick(2);
    bus.key_l = 1'b0;
    tick(4);
    chk("hold5.single", 32'(bus.lights), 32'h020);
    press(0, 1);
    chk("back_centre", 32'(bus.lights), 32'h010);
    for (int i = 0; i < 4; i++) press(0, 1);
    chk("right_end", 32'(bus.lights), 32'h001);
    press(0, 1);
    chk_all("rwin", 9'b0, 0, 1, 0, 1, 0);
    tick(3);
    chk_all("rwin.hold4", 9'b0, 0, 1, 0, 1, 0);
    tick(1);
    chk_all("rwin.recentre", 9'b000010000, 0, 0, 0, 1, 0);
    press(1, 1);
    chk_all("both.centre", 9'b000010000, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) press(1, 0);
    chk("left_end", 32'(bus.lights), 32'h100);
    press(1, 1);
    chk_all("both.end", 9'b100000000, 0, 0, 0, 1, 0);
    // winning pulse, then two more key_l presses that land inside HOLD
    bus.key_l = 1'b1;
    tick(1);
    bus.key_l = 1'b0;
    tick(1);
    bus.key_l = 1'b1;
    tick(1);
    chk_all("lwin", 9'b0, 1, 0, 1, 1, 0);
    bus.key_l = 1'b0;
    tick(1);
    bus.key_l = 1'b1;
    tick(1);
    bus.key_l = 1'b0;
    tick(1);
    chk_all("lwin.hold_keys", 9'b0, 1, 0, 1, 1, 0);
    tick(1);
    chk_all("lwin.recentre", 9'b000010000, 0, 0, 1, 1, 0);
    press(1, 0);
    chk("after_hold.move", 32'(bus.lights), 32'h020);
    for (int i = 0; i < 4; i++) press(1, 0);
    chk("round2.win", 32'(bus.score_l), 32'd2);
    tick(4);
    for (int rnd = 3; rnd <= 6; rnd++) begin
      for (int i = 0; i < 5; i++) press(1, 0);
      chk("roundN.win", 32'(bus.score_l), 32'(rnd));
      tick(4);
    end
    for (int i = 0; i < 5; i++) press(1, 0);
    chk_all("match", 9'b0, 1, 0, 7, 1, 1);
    tick(6);
    press(1, 0);
    press(0, 1);
    press(1, 1);
    tick(3);
    chk_all("match.frozen", 9'b0, 1, 0, 7, 1, 1);
    reset = 1'b0;
    tick(1);
    chk_all("reset_done", 9'b000010000, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) press(0, 1);
    chk_all("rwin2", 9'b0, 0, 1, 0, 1, 0);
    tick(1);
    #2 reset = 1'b0;
    #1 chk_all("async_reset", 9'b000010000, 0, 0, 0, 0, 0);
    tick(1);
    reset = 1'b1;
    tick(2);
    chk_all("post_reset", 9'b000010000, 0, 0, 0, 0, 0);
    press(1, 0);
    chk("post_reset.move", 32'(bus.lights), 32'h020);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tug_of_war_ctrl.md
Name: tug_of_war_ctrl

Overview:
- Playfield controller for the tug-of-war game. Owns the row of position lights that the per-position light cells implement today, and centralises the sequencing they currently do locally.
- Takes the two player keys, then synchronises and edge-detects them. Moves a single lit position left or right, detects a win at either end, and keeps per-player round scores.
- Holds the win display for a fixed time, then re-centres the light. Ends the match when either score saturates.

Parameters:
- NUM_LIGHTS, 9, number of positions. Must be odd and ≥3. Centre index is C = NUM_LIGHTS/2 (integer division).
- SCORE_W, 3, width of each score counter. Match point is 2^SCORE_W−1.
- HOLD_CYCLES, 4, clock cycles the win display is held before the next round. Must be ≥1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset. Low clears all state immediately, independent of clk.
- key_l  in  1  left player key, level, asynchronous to clk.
- key_r  in  1  right player key, level, asynchronous to clk.
- lights  out  NUM_LIGHTS  playfield. Bit NUM_LIGHTS−1 is the leftmost position, bit 0 the rightmost.
- win_l  out  1  high while the left player's round win is being displayed, or after the left player wins the match.
- win_r  out  1  same as win_l, for the right player.
- score_l  out  SCORE_W  rounds won by the left player.
- score_r  out  SCORE_W  rounds won by the right player.
- match_over  out  1  high once either score reaches match point.

Behaviour:
- Reset (reset low, asynchronous):
  - state=PLAY, position=C, lights = one-hot at C.
  - win_l=win_r=0, score_l=score_r=0, match_over=0.
  - Synchroniser and edge flops cleared, hold counter=0.
  - Assertion mid-round, mid-hold or after match over aborts immediately. Release resumes in PLAY at centre.
- Input path, per key:
  - Two-flop synchroniser, then a previous-value flop.
  - press = sync2 & ~prev, a one-cycle pulse per rising edge of the key.
  - A key held high produces exactly one press.
  - Latency: key rises before edge E0 → sync1 at E0, sync2 at E1, and the position update takes effect at E2. Lights change after the 3rd rising edge.
- State machine (PLAY, HOLD, DONE):
  - PLAY:
    - press_l only, position<NUM_LIGHTS−1: position+1.
    - press_r only, position>0: position−1.
    - press_l & press_r in the same cycle: no move, no score.
    - press_l only at position=NUM_LIGHTS−1: left wins the round.
    - press_r only at position=0: right wins the round.
    - On a left round win: score_l+1, win_l=1, lights=0, hold counter=0. Go to DONE if the new score equals 2^SCORE_W−1, else HOLD. Right win mirrors this.
  - HOLD:
    - lights=0, keys ignored (press pulses discarded; sync flops keep running).
    - Counter increments each cycle.
    - When the counter reaches HOLD_CYCLES−1: next edge clears win_l/win_r, sets position=C, goes to PLAY.
    - The win display therefore lasts exactly HOLD_CYCLES cycles.
  - DONE:
    - lights=0, match_over=1, winning win_x held at 1.
    - Keys ignored. Leaves only via reset.
- Score arithmetic: unsigned. It cannot overflow because DONE is entered at max.
- All outputs registered except lights, which is decoded from position and state.
- lights is always either one-hot (PLAY) or zero (HOLD/DONE). win_l and win_r are never both 1.

Test Plan:
- Reset, then key_l pulse high 5 cycles → exactly one move: lights 9'b000010000 → 9'b000100000 on the 3rd edge after the rise, then stable.
- From centre, 4 separate key_r presses → lights reaches 9'b000000001. 5th press → win_r=1, score_r=1, lights=0 for 4 cycles, then lights=9'b000010000, win_r=0.
- key_l and key_r rising in the same cycle at centre → lights unchanged 9'b000010000, scores unchanged. Repeat at position 8 → no win.
- Presses during HOLD (key_l toggled twice) → ignored. The light re-centres at the scheduled cycle and the first PLAY press moves it normally.
- Left wins 7 rounds (SCORE_W=3) → after the 7th: score_l=7, match_over=1, win_l=1, lights=0. Further presses change nothing.
- reset driven low mid-HOLD, between clock edges → all outputs clear immediately without a clock edge. After release, lights=9'b000010000 and scores=0.
